imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Byte-serial boot loader that writes a program image into the instruction memory, which the processor core reads on its fetch path.
- It accepts a framed byte stream, assembles big-endian 32-bit words and issues one write per word at sequential addresses from 0.
- It holds the core in reset (cpu_hold) until the image checksum verifies.
- It sits beside processor at SoC top; instruction_memory gains a write port driven from here.

Parameters:
- ADDR_W, 4, instruction memory word-address width (matches 4-bit PC); capacity 2^ADDR_W words.
- START_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid this cycle
- rx_ready  output  1  loader can accept a byte this cycle
- imem_we  output  1  instruction memory write strobe, one cycle per word
- imem_addr  output  ADDR_W  word address for the write
- imem_wdata  output  32  word to write
- cpu_hold  output  1  high = keep processor in reset
- done  output  1  image loaded and verified
- error  output  1  frame rejected

Behaviour:
- Byte transfer occurs on a rising edge where rx_valid && rx_ready. rx_data is ignored otherwise.
- rx_ready is Moore: it is 1 in every state except WRITE.
- Reset (async, any time, including mid-frame):
  - state=IDLE, cpu_hold=1, done=0, error=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - Byte counter, word counter and checksum are cleared.
  - Partially written memory is left as is.
- IDLE: a START_BYTE goes to COUNT. Any other byte is accepted and discarded.
- COUNT: the byte is N, the word count.
  - N=0 or N>2^ADDR_W: go to ERROR.
  - Otherwise latch N, clear addr/checksum/byte index, go to DATA.
- DATA: each byte shifts into imem_wdata from MSB down (first byte goes to [31:24]), and the checksum is XORed with the byte. On the 4th byte, go to WRITE.
- WRITE: one cycle.
  - imem_we=1 with imem_addr and imem_wdata stable; the memory captures the word at the closing edge.
  - On exit, imem_addr increments and the word counter increments.
  - If word counter reaches N, go to CHECK; else go to DATA.
  - imem_we is 0 in all other states.
- CHECK: the byte is compared with the XOR of all 4N data bytes.
  - Match: go to DONE.
  - Mismatch: go to ERROR.
- DONE: cpu_hold=0, done=1, error=0. A START_BYTE goes to COUNT with cpu_hold=1 and done=0, so a reload restarts the core. Other bytes are discarded.
- ERROR: cpu_hold=1, error=1, done=0. Exit only via START_BYTE (to COUNT, error clears) or rst.
- cpu_hold, done and error are registered and change on the same edge as the state change.
- imem_addr wraps within ADDR_W bits. N is bounded, so wrap never produces an overlapping write.
- A START_BYTE value inside DATA/CHECK is treated as data. There is no resync mid-frame.
- Latency: 4th data byte accepted at edge k; imem_we high for cycle k..k+1; next byte acceptable from edge k+1.

Test Plan:
- Good load: A5, 02, 20 08 00 05, 00 00 00 00, 2D → writes 0x20080005@0 and 0x00000000@1, each imem_we exactly one cycle with rx_ready=0. After the checksum edge, done=1, cpu_hold=0, error=0.
- Bad checksum: same frame with final byte 2C → both words written; error=1, cpu_hold=1, done=0.
- Count bounds:
  - A5, 00 → ERROR with no writes.
  - A5, 11 (17 > 16) → ERROR.
  - A5, 10 with 64 bytes and a correct checksum → 16 writes at addr 0..15, then DONE.
- Reset mid-frame: assert rst after 2 data bytes of word 1 → outputs immediately at reset values. A subsequent full good frame loads correctly from addr 0.
- Reload from DONE: after a good load, send A5 → cpu_hold rises and done falls on the acceptance edge. A second good frame with different words overwrites from addr 0 and ends in DONE.
- Backpressure/noise: rx_valid pulses with random gaps, garbage bytes (00, FF) in IDLE, rx_valid held high across WRITE → no byte lost or duplicated; result matches the good-load case.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-serial boot loader: framed stream -> big-endian 32-bit words written to instruction memory.
// Holds the core in reset until the frame's XOR checksum verifies.
module imem_loader #(
  parameter int unsigned ADDR_W     = 4,
  parameter logic [7:0]  START_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [2:0]        state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [7:0]        words_q, words_d;
  logic [7:0]        csum_q, csum_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              accept;
  logic              count_ok;
  logic              is_start;

  assign rx_ready   = (state_q != S_WRITE);
  assign accept     = rx_valid && rx_ready;
  assign is_start   = (rx_data == START_BYTE);
  assign count_ok   = (rx_data != 8'd0) && ({24'd0, rx_data} <= DEPTH);
  assign imem_we    = (state_q == S_WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign error      = error_q;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    words_d    = words_q;
    csum_d     = csum_q;
    byte_idx_d = byte_idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    done_d     = done_q;
    error_d    = error_q;
    case (state_q)
      S_IDLE: begin
        if (accept && is_start) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (accept) begin
          if (count_ok) begin
            n_d        = rx_data;
            words_d    = 8'd0;
            csum_d     = 8'd0;
            byte_idx_d = 2'd0;
            addr_d     = '0;
            state_d    = S_DATA;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
            hold_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          wdata_d    = {wdata_q[23:0], rx_data};
          csum_d     = csum_q ^ rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 1'b1;
        words_d = words_q + 8'd1;
        state_d = (words_q + 8'd1 == n_q) ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        if (accept) begin
          if (rx_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
            error_d = 1'b0;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
            hold_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
      end
      S_DONE, S_ERROR: begin
        // A new frame re-asserts the core hold so a reload restarts the processor.
        if (accept && is_start) begin
          state_d = S_COUNT;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= 8'd0;
      words_q    <= 8'd0;
      csum_q     <= 8'd0;
      byte_idx_q <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      words_q    <= words_d;
      csum_q     <= csum_d;
      byte_idx_q <= byte_idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-level reference model, write scoreboard and
// per-cycle output checks, with randomized gaps, garbage bytes and random frames.
`timescale 1ns/1ps
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  imem_loader #(.ADDR_W(4), .START_BYTE(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] tb_mem[16];
  logic [31:0] model_mem[16];
  logic [31:0] fw[16];
  logic        gaps_on = 1'b0;
  logic        prev_we = 1'b0;
  logic [7:0]  last_csum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Write scoreboard: the bench plays the instruction memory.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_we = 1'b0;
      end else begin
        chk("rx_ready_low_only_in_write", rx_ready, !imem_we);
        if (imem_we) begin
          chk("we_single_cycle", prev_we, 1'b0);
          if (exp_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write addr=%0d data=%h expected=none", imem_addr, imem_wdata);
          end else begin
            chk("write_addr", imem_addr, exp_addr.pop_front());
            chk("write_data", imem_wdata, exp_data.pop_front());
          end
          tb_mem[imem_addr] = imem_wdata;
        end
        prev_we = imem_we;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    if (gaps_on && $urandom_range(0, 2) == 0) begin
      repeat ($urandom_range(1, 4)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout actual=0 expected=1");
    end else begin
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic garbage();
    send_byte(8'h00);
    send_byte(8'hFF);
  endtask

  // Frame-level model: bad count -> error, no writes; else words land at 0..n-1, checksum decides.
  task automatic run_frame(input int n, input logic [7:0] csum_flip);
    logic [7:0] cs = 8'd0;
    logic       bad;
    send_byte(8'hA5);
    chk("hold_after_start", cpu_hold, 1'b1);
    chk("done_after_start", done, 1'b0);
    chk("error_after_start", error, 1'b0);
    if (n == 0 || n > 16) begin
      send_byte(n[7:0]);
      chk("bad_count_error", error, 1'b1);
      chk("bad_count_done", done, 1'b0);
      chk("bad_count_hold", cpu_hold, 1'b1);
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(4'(i));
      exp_data.push_back(fw[i]);
      model_mem[i] = fw[i];
      cs = cs ^ fw[i][31:24] ^ fw[i][23:16] ^ fw[i][15:8] ^ fw[i][7:0];
    end
    last_csum = cs;
    bad = (csum_flip != 8'd0);
    send_byte(n[7:0]);
    for (int i = 0; i < n; i++) begin
      send_byte(fw[i][31:24]);
      send_byte(fw[i][23:16]);
      send_byte(fw[i][15:8]);
      send_byte(fw[i][7:0]);
    end
    send_byte(cs ^ csum_flip);
    chk("end_done", done, !bad);
    chk("end_error", error, bad);
    chk("end_hold", cpu_hold, bad);
    chk("all_writes_seen", exp_addr.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    for (int i = 0; i < 16; i++) begin
      tb_mem[i]    = 32'd0;
      model_mem[i] = 32'd0;
    end
    #1;
    chk("rst_hold", cpu_hold, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_we", imem_we, 1'b0);
    chk("rst_addr", imem_addr, 4'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_ready", rx_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Good load
    fw[0] = 32'h2008_0005;
    fw[1] = 32'h0000_0000;
    run_frame(2, 8'h00);
    chk("good_csum_model", last_csum, 8'h2D);
    chk("good_mem0", tb_mem[0], 32'h2008_0005);
    chk("good_mem1", tb_mem[1], 32'h0000_0000);

    // Bad checksum (final byte 2C)
    run_frame(2, 8'h01);
    chk("bad_mem0", tb_mem[0], 32'h2008_0005);

    // Count bounds
    run_frame(0, 8'h00);
    run_frame(17, 8'h00);
    for (int i = 0; i < 16; i++) fw[i] = $urandom;
    run_frame(16, 8'h00);

    // Reset mid-frame: word 0 written, 2 bytes of word 1 accepted
    fw[0] = 32'h1122_3344;
    fw[1] = 32'h5566_7788;
    send_byte(8'hA5);
    send_byte(8'h02);
    exp_addr.push_back(4'd0);
    exp_data.push_back(fw[0]);
    model_mem[0] = fw[0];
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    chk("pre_reset_writes", exp_addr.size(), 0);
    rst = 1'b1;
    #1;
    chk("midrst_hold", cpu_hold, 1'b1);
    chk("midrst_done", done, 1'b0);
    chk("midrst_error", error, 1'b0);
    chk("midrst_we", imem_we, 1'b0);
    chk("midrst_addr", imem_addr, 4'd0);
    chk("midrst_wdata", imem_wdata, 32'd0);
    chk("midrst_mem0", tb_mem[0], 32'h1122_3344);
    exp_addr.delete();
    exp_data.delete();
    @(negedge clk);
    rst = 1'b0;
    fw[0] = 32'hCAFE_0001;
    fw[1] = 32'hBEEF_0002;
    run_frame(2, 8'h00);
    chk("after_rst_mem0", tb_mem[0], 32'hCAFE_0001);

    // Reload from DONE with different words
    fw[0] = 32'h0102_0304;
    fw[1] = 32'hA5A5_A5A5;
    fw[2] = 32'hFFFF_0000;
    run_frame(3, 8'h00);
    chk("reload_mem2", tb_mem[2], 32'hFFFF_0000);

    // Backpressure and noise, then good-load image again
    gaps_on = 1'b1;
    garbage();
    fw[0] = 32'h2008_0005;
    fw[1] = 32'h0000_0000;
    run_frame(2, 8'h00);
    chk("noisy_mem0", tb_mem[0], 32'h2008_0005);
    chk("noisy_mem1", tb_mem[1], 32'h0000_0000);

    // Random frames
    repeat (8) begin
      int n;
      logic [7:0] flip;
      n = $urandom_range(1, 16);
      for (int i = 0; i < 16; i++) fw[i] = $urandom;
      flip = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      if ($urandom_range(0, 1) == 0) garbage();
      run_frame(n, flip);
    end

    for (int i = 0; i < 16; i++) chk("final_mem", tb_mem[i], model_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
